debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised N-channel switch debouncer. Successor to the fixed two-switch debouncer and LED-demo wrapper.
- Per channel: synchronises the raw pin and filters bounce with a stable-sample counter.
- Per channel outputs: debounced level, single-cycle press and release pulses, a mode-selectable toggle register and a one-shot long-press pulse.
- Sits between board push-buttons/DIP switches and user logic. Replaces per-switch debouncer instances plus hand-written toggle logic.

Parameters:
- N, 4, number of independent channels (1..32).
- STABLE_CYCLES, 16, consecutive cycles a synchronised input must differ from the debounced state before the state changes (≥2).
- HOLD_CYCLES, 1024, cycles the debounced state must stay pressed before `hold_pulse` fires (> STABLE_CYCLES).
- ACTIVE_LOW, {N{1'b1}}, per-channel mask. Bit set means the pin reads 0 when pressed; the channel is inverted after synchronisation.
- TOGGLE_ON_RELEASE, {N{1'b0}}, per-channel mask. 0 means `toggle` flips on press; 1 means it flips on release.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- switch_in  input  N  raw asynchronous pins.
- state  output  N  debounced pressed level (1 = pressed), registered.
- press_pulse  output  N  one-cycle pulse on debounced 0→1.
- release_pulse  output  N  one-cycle pulse on debounced 1→0.
- toggle  output  N  flips once per press or release, per TOGGLE_ON_RELEASE.
- hold_pulse  output  N  one-cycle pulse after HOLD_CYCLES continuous press.

Behaviour:
- Reset applies immediately while RST_N = 0, regardless of CLK:
  - Synchroniser flops for channel i load ACTIVE_LOW[i], i.e. the idle pin level, so leaving reset creates no event.
  - `state`, `press_pulse`, `release_pulse`, `toggle`, `hold_pulse`, all counters and all latches are 0.
- Synchroniser:
  - Two flops per channel; `s_i` is the second flop output XOR ACTIVE_LOW[i].
  - Adds 2 cycles of latency. No logic on raw pins except the first flop.
- Stability counter `cnt_i` (width `$clog2(STABLE_CYCLES)`, minimum 1):
  - If `s_i == state[i]`: `cnt_i <= 0`.
  - Otherwise, if `cnt_i == STABLE_CYCLES-1`: `state[i] <= s_i` and `cnt_i <= 0`.
  - Otherwise: `cnt_i <= cnt_i + 1`.
  - Any glitch back to `state[i]` clears the count. The count never wraps.
- Latency: a clean pin edge appears on `state` exactly 2 + STABLE_CYCLES rising CLK edges later.
- Edge pulses:
  - `press_pulse[i]` is high for exactly the one cycle in which `state[i]` first reads 1 after a 0→1 update.
  - `release_pulse[i]` behaves the same for 1→0.
  - Both are registered and asserted on the same edge that updates `state`. They are never high together.
- Toggle:
  - Flips on the edge that raises `press_pulse[i]` when TOGGLE_ON_RELEASE[i] = 0.
  - Flips on the edge that raises `release_pulse[i]` when TOGGLE_ON_RELEASE[i] = 1.
  - `toggle` itself changes on the edge after the pulse cycle, i.e. one cycle after `state`.
- Hold counter `hcnt_i` (width `$clog2(HOLD_CYCLES+1)`) and `hold_done_i` latch:
  - While `state[i]` = 0: `hcnt_i` and `hold_done_i` are cleared.
  - While `state[i]` = 1 and `hold_done_i` = 0: `hcnt_i` increments.
  - When `hcnt_i` reaches HOLD_CYCLES-1, `hold_pulse[i]` is high for one cycle and `hold_done_i` sets.
  - Result: exactly one pulse per press, HOLD_CYCLES cycles after `state` rose. No repeat.
  - Release before that point produces no `hold_pulse`. The counter saturates via `hold_done_i` and never wraps.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- A pin toggling faster than STABLE_CYCLES never changes `state`.
- Reset mid-count or mid-hold aborts the operation. No pulse is emitted during or after reset for the aborted event.
- Parameter legality is checked at elaboration; illegal values stop elaboration:
  - STABLE_CYCLES < 2
  - HOLD_CYCLES ≤ STABLE_CYCLES
  - N outside 1..32

Test Plan:
- Settings for all scenarios: N=4, STABLE_CYCLES=8, HOLD_CYCLES=32, ACTIVE_LOW=4'b1111, TOGGLE_ON_RELEASE=4'b0010.
- Reset release with all pins high (idle) → all outputs stay 0 for 100 cycles.
- Clean press:
  - Stimulus: pin0 1→0 at cycle T.
  - Required: `state[0]` = 1 and `press_pulse[0]` = 1 at T+10 only; `toggle[0]` = 1 from T+11.
  - Held 40 cycles: `hold_pulse[0]` fires once, 32 cycles after `state[0]` rose.
- Bounce:
  - Stimulus: pin1 toggles every 3 cycles for 60 cycles, then settles low.
  - Required: no pulses during bouncing; single `press_pulse[1]` 10 cycles after settling; `toggle[1]` unchanged.
  - On the following release: `release_pulse[1]` and `toggle[1]` → 1.
- Short press:
  - Stimulus: pin2 low for 20 cycles.
  - Required: `press_pulse` and `release_pulse` each fire once; no `hold_pulse`.
- Concurrency and reset:
  - Stimulus: pins 0 and 3 pressed on the same cycle.
  - Required: `press_pulse` = 4'b1001 in one cycle.
  - Assert RST_N during pin3's hold count: all outputs go to 0 immediately; no `hold_pulse` after release of reset while the pin stays low until re-debounced.
- Glitch:
  - Stimulus: 7-cycle low pulse on pin0.
  - Required: `state[0]` never changes; counter returns to 0.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel push-button/switch debouncer with
// edge, toggle and long-press outputs per channel.
module debounce_bank #(
  parameter int N = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter logic [N-1:0] ACTIVE_LOW = {N{1'b1}},
  parameter logic [N-1:0] TOGGLE_ON_RELEASE = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] switch_in,
  output logic [N-1:0] state,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] toggle,
  output logic [N-1:0] hold_pulse
);

  localparam int CW =
    (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  if (N < 1 || N > 32) begin : g_bad_n
    $fatal(1, "debounce_bank: N must be 1..32");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $fatal(1, "debounce_bank: STABLE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES <= STABLE_CYCLES) begin : g_bad_hold
    $fatal(1, "debounce_bank: HOLD_CYCLES must exceed STABLE_CYCLES");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          s;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          hold_done;
    logic          tog_ev;

    // Sync flops idle at the unpressed pin level.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1 <= ACTIVE_LOW[i];
        sync2 <= ACTIVE_LOW[i];
      end else begin
        sync1 <= switch_in[i];
        sync2 <= sync1;
      end
    end

    assign s = sync2 ^ ACTIVE_LOW[i];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt              <= '0;
        state[i]         <= 1'b0;
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
      end else begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        if (s == state[i]) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt              <= '0;
          state[i]         <= s;
          press_pulse[i]   <= s;
          release_pulse[i] <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign tog_ev = TOGGLE_ON_RELEASE[i] ?
                    release_pulse[i] : press_pulse[i];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        toggle[i] <= 1'b0;
      end else if (tog_ev) begin
        toggle[i] <= ~toggle[i];
      end
    end

    // hold_done parks the counter so a long press fires only once.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        hcnt          <= '0;
        hold_done     <= 1'b0;
        hold_pulse[i] <= 1'b0;
      end else begin
        hold_pulse[i] <= 1'b0;
        if (!state[i]) begin
          hcnt      <= '0;
          hold_done <= 1'b0;
        end else if (!hold_done) begin
          if (hcnt == HOLD_MAX) begin
            hold_pulse[i] <= 1'b1;
            hold_done     <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of debounce_bank with
// STABLE_CYCLES=8, HOLD_CYCLES=32, toggle-on-release on channel 1.
module tb_debounce_bank;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] switch_in = 4'hF;
  logic [3:0] state;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] toggle;
  logic [3:0] hold_pulse;

  debounce_bank #(
    .N                 (4),
    .STABLE_CYCLES     (8),
    .HOLD_CYCLES       (32),
    .ACTIVE_LOW        (4'b1111),
    .TOGGLE_ON_RELEASE (4'b0010)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .switch_in     (switch_in),
    .state         (state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .toggle        (toggle),
    .hold_pulse    (hold_pulse)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] e_st = '0;
  logic [3:0] e_pp = '0;
  logic [3:0] e_rp = '0;
  logic [3:0] e_tg = '0;
  logic [3:0] e_hp = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field order: state, press, release, toggle, hold.
  task automatic check_outs(input string tag, input int cyc);
    check($sformatf("%s@%0d", tag, cyc),
          {12'd0, state, press_pulse, release_pulse,
           toggle, hold_pulse},
          {12'd0, e_st, e_pp, e_rp, e_tg, e_hp});
  endtask

  task automatic clr_pulses();
    e_pp = '0;
    e_rp = '0;
    e_hp = '0;
  endtask

  initial begin
    #3 check_outs("reset", 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      check_outs("idle", i);
    end

    // Clean press and long hold on channel 0.
    switch_in[0] = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[0] = 1'b1;
        e_pp[0] = 1'b1;
      end
      if (i == 11) e_tg[0] = 1'b1;
      if (i == 42) e_hp[0] = 1'b1;
      check_outs("press0", i);
    end
    switch_in[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[0] = 1'b0;
        e_rp[0] = 1'b1;
      end
      check_outs("rel0", i);
    end

    // Bouncing channel 1, then settle pressed.
    for (int k = 0; k < 20; k++) begin
      switch_in[1] = ~switch_in[1];
      for (int j = 0; j < 3; j++) begin
        @(negedge CLK);
        clr_pulses();
        check_outs("bounce1", k * 3 + j);
      end
    end
    switch_in[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[1] = 1'b1;
        e_pp[1] = 1'b1;
      end
      check_outs("settle1", i);
    end
    switch_in[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[1] = 1'b0;
        e_rp[1] = 1'b1;
      end
      if (i == 11) e_tg[1] = 1'b1;
      check_outs("rel1", i);
    end

    // Short press on channel 2: no hold pulse.
    switch_in[2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[2] = 1'b1;
        e_pp[2] = 1'b1;
      end
      if (i == 11) e_tg[2] = 1'b1;
      check_outs("short2", i);
    end
    switch_in[2] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[2] = 1'b0;
        e_rp[2] = 1'b1;
      end
      check_outs("rel2", i);
    end

    // Channels 0 and 3 together, reset mid-hold.
    switch_in[0] = 1'b0;
    switch_in[3] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st = e_st | 4'b1001;
        e_pp = 4'b1001;
      end
      if (i == 11) e_tg = e_tg ^ 4'b1001;
      check_outs("conc", i);
    end
    #2 RST_N = 1'b0;
    #1;
    e_st = '0;
    e_tg = '0;
    clr_pulses();
    check_outs("rst_async", 0);
    @(negedge CLK);
    @(negedge CLK);
    check_outs("rst_hold", 1);
    RST_N = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st = 4'b1001;
        e_pp = 4'b1001;
      end
      if (i == 11) e_tg = 4'b1001;
      if (i == 42) e_hp = 4'b1001;
      check_outs("post_rst", i);
    end
    switch_in = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st = 4'b0000;
        e_rp = 4'b1001;
      end
      check_outs("rel03", i);
    end

    // 7-cycle glitch on channel 0 is filtered out.
    switch_in[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      clr_pulses();
      check_outs("glitch0", i);
    end
    switch_in[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      clr_pulses();
      check_outs("post_glitch0", i);
    end
    // Full latency again proves the count was cleared.
    switch_in[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      clr_pulses();
      if (i == 10) begin
        e_st[0] = 1'b1;
        e_pp[0] = 1'b1;
      end
      if (i == 11) e_tg[0] = 1'b0;
      check_outs("repress0", i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
